// File: rtl/riscv_pkg.sv
// Shared constants for the fetch front end: datapath width, the canonical NOP,
// and the default prefetch queue depth.
package riscv_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned QUEUE_DEPTH = 4;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : riscv_pkg

// File: rtl/instr_fetch_queue.sv
// Prefetch FIFO between fetch and decode. It holds {pc, instr} pairs in order,
// lets fetch run ahead while decode stalls, and drops everything on a redirect.
// Head entry is read combinationally; an empty queue presents pc=0 and a NOP.
module instr_fetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = riscv_pkg::XLEN,
    parameter int unsigned DEPTH = riscv_pkg::QUEUE_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_instr,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    // Storage is intentionally not reset; out_* are masked while empty.
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    logic push;
    logic pop;

    // Handshake decode; pointers depend only on these, never on data.
    always_comb begin
        in_ready  = (count_q != FULL_COUNT);
        out_valid = (count_q != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // Next-state for pointers and occupancy; flush overrides any handshake.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Capture accepted pairs; a flushed push is discarded along with the queue.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr_q]    <= in_pc;
            instr_mem[wr_ptr_q] <= in_instr;
        end
    end

    // Head presentation, masked to pc=0 / NOP while empty.
    always_comb begin
        if (out_valid) begin
            out_pc    = pc_mem[rd_ptr_q];
            out_instr = instr_mem[rd_ptr_q];
        end else begin
            out_pc    = '0;
            out_instr = XLEN'(NOP_INSTR);
        end
    end

    assign count = count_q;

endmodule : instr_fetch_queue

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_instr_fetch_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic [2:0]      count;

    int checks = 0;
    int errors = 0;

    // Reference model: entries in arrival order, head at index 0.
    logic [XLEN-1:0] m_pc[$];
    logic [XLEN-1:0] m_instr[$];

    instr_fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        int n;
        n = m_pc.size();
        chk({tag, ".count"},     64'(count),     64'(n));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(n != 0));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(n != DEPTH));
        chk({tag, ".out_pc"},    64'(out_pc),    64'((n != 0) ? m_pc[0] : 32'h0));
        chk({tag, ".out_instr"}, 64'(out_instr), 64'((n != 0) ? m_instr[0] : NOP));
    endtask

    // One clock: drive at negedge, check state, clock it, update the model.
    task automatic cycle(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic rdy, input logic fl);
        bit do_push;
        bit do_pop;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = rdy;
        flush     = fl;
        #1;
        check_outputs(tag);
        do_push = v && (m_pc.size() < DEPTH);
        do_pop  = rdy && (m_pc.size() != 0);
        @(posedge clk);
        if (fl) begin
            m_pc.delete();
            m_instr.delete();
        end else begin
            if (do_pop) begin
                void'(m_pc.pop_front());
                void'(m_instr.pop_front());
            end
            if (do_push) begin
                m_pc.push_back(pc);
                m_instr.push_back(ins);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;

        // 1: reset held for two cycles
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;

        // 2: fill to full, then a fifth push is refused
        for (int i = 0; i < 4; i++) begin
            cycle("fill", 1'b1, 32'(i * 4), 32'hA000_0000 | 32'(i), 1'b0, 1'b0);
        end
        cycle("full_push", 1'b1, 32'd16, 32'hA000_0004, 1'b0, 1'b0);
        check_outputs("after_full_push");

        // 3: drain in order
        for (int i = 0; i < 4; i++) begin
            cycle("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        check_outputs("drained");

        // 4: concurrent push/pop at count 2 (X data with in_valid low is harmless)
        cycle("c_fill0", 1'b1, 32'd100, 32'hB000_0000, 1'b0, 1'b0);
        cycle("c_idle",  1'b0, 32'hx,   32'hx,         1'b0, 1'b0);
        cycle("c_fill1", 1'b1, 32'd104, 32'hB000_0001, 1'b0, 1'b0);
        cycle("c_both",  1'b1, 32'd20,  32'hB000_0002, 1'b1, 1'b0);
        check_outputs("after_concurrent");

        // 5: flush at count 3 discards the simultaneous push
        cycle("f_fill", 1'b1, 32'd24, 32'hC000_0000, 1'b0, 1'b0);
        cycle("flush",  1'b1, 32'd28, 32'hC000_0001, 1'b1, 1'b1);
        check_outputs("after_flush");
        cycle("refetch", 1'b1, 32'd200, 32'hC000_0002, 1'b0, 1'b0);
        check_outputs("after_refetch");

        // 6: pointer wrap traffic, then asynchronous reset between edges
        for (int i = 0; i < 10; i++) begin
            cycle("wrap", 1'b1, 32'd300 + 32'(i * 4), $urandom, 1'(i % 3 != 0), 1'b0);
        end
        #2 rst = 1'b1;
        #1;
        m_pc.delete();
        m_instr.delete();
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        cycle("post_rst", 1'b1, 32'd400, 32'hD000_0000, 1'b0, 1'b0);
        check_outputs("post_rst_accept");

        // Randomized traffic with occasional redirects
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end
        check_outputs("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instr_fetch_queue
